// File: rtl/cpu_clock_pkg.sv
// Shared types for the CPU slow-clock controller: FSM states and run-mode encodings.
package cpu_clock_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, BURST = 2'd3} state_t;
   typedef enum logic [1:0] {M_RUN = 2'd0, M_PAUSE = 2'd1, M_STEP = 2'd2, M_BURST = 2'd3} mode_t;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser carrying a trigger bit (rising-edge detected) plus passenger level bits.
// o_vld rises once the chain has been refilled after reset, so cleared flops are never read as live data.
module sync_edge #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_trig,
   input  logic [WIDTH-1:0] i_lvl,
   output logic [WIDTH-1:0] o_lvl,
   output logic             o_rise,
   output logic             o_vld
);
   logic [WIDTH+1:0] r_sync [STAGES];
   logic             r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync[0] <= {i_lvl, i_trig, 1'b1};
         for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= r_sync[STAGES-1][1];
      end
   end

   assign o_lvl  = r_sync[STAGES-1][WIDTH+1:2];
   assign o_rise = r_sync[STAGES-1][1] & ~r_prev;
   assign o_vld  = r_sync[STAGES-1][0];
endmodule

// File: rtl/cpu_clock_ctrl.sv
// Slow CPU clock generator from clk_2: programmable divider, RUN/PAUSE/STEP/BURST modes, cycle counter.
// Optional breakpoint halt is compiled in with `define BREAKPOINT_EN.
module cpu_clock_ctrl
   import cpu_clock_pkg::*;
#(
   parameter int DIV_BITS    = 4,
   parameter int NBITS       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_2,
   input  logic                reset,
   input  logic [DIV_BITS-1:0] div,
   input  logic [1:0]          mode,
   input  logic                step,
   input  logic [NBITS-1:0]    burst_len,
`ifdef BREAKPOINT_EN
   input  logic [NBITS-1:0]    pc,
   input  logic [NBITS-1:0]    bkpt,
   input  logic                bkpt_valid,
   output logic                bkpt_hit,
`endif
   output logic                clock,
   output logic                tick,
   output logic                busy,
   output logic [NBITS-1:0]    ncycles,
   output logic [1:0]          state
);
   localparam logic [DIV_BITS-1:0] C_ONE = DIV_BITS'(1);
   localparam logic [NBITS-1:0]    N_ONE = NBITS'(1);

   state_t              r_state, w_state_n;
   logic [DIV_BITS-1:0] r_cnt, r_div;
   logic [NBITS-1:0]    r_ncyc, r_remain;
   logic                r_clk, r_tick;
   logic [1:0]          w_mode_lvl;
   mode_t               w_mode;
   logic                w_step_rise, w_sync_vld, w_active, w_wrap, w_rise, w_fall, w_stay;
   logic                w_bkpt, w_park;

   sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync (
      .i_clk(clk_2), .i_rst_n(reset), .i_trig(step), .i_lvl(mode),
      .o_lvl(w_mode_lvl), .o_rise(w_step_rise), .o_vld(w_sync_vld)
   );

   assign w_mode   = mode_t'(w_mode_lvl);
   assign w_active = (r_state != IDLE);
   assign w_wrap   = w_active && (r_cnt == r_div);
   assign w_rise   = w_wrap && !r_clk;
   assign w_fall   = w_wrap && r_clk;
   assign w_stay   = (w_state_n != IDLE);

`ifdef BREAKPOINT_EN
   logic r_bkpt_hit, r_park;
   assign w_bkpt   = bkpt_valid && (pc == bkpt);
   assign w_park   = r_park;
   assign bkpt_hit = r_bkpt_hit;

   // After a breakpoint halt, RUN stays parked until the mode switch leaves RUN.
   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
         r_bkpt_hit <= 1'b0;
         r_park     <= 1'b0;
      end else begin
         if (!w_active && w_stay)
            r_bkpt_hit <= 1'b0;
         else if ((r_state == RUN || r_state == BURST) && w_fall && w_bkpt)
            r_bkpt_hit <= 1'b1;
         if (r_state == RUN && w_fall && w_bkpt) r_park <= 1'b1;
         else if (w_mode != M_RUN)                r_park <= 1'b0;
      end
   end
`else
   assign w_bkpt = 1'b0;
   assign w_park = 1'b0;
`endif

   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_n;
   end

   // Stops requested while clock is low take effect at once; while high, at the falling edge.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE: begin
            if (w_sync_vld && w_mode == M_RUN && !w_park)                     w_state_n = RUN;
            else if (w_step_rise && w_mode == M_STEP)                          w_state_n = STEP;
            else if (w_step_rise && w_mode == M_BURST && burst_len != '0)      w_state_n = BURST;
         end
         RUN: begin
            if ((w_mode != M_RUN && !r_clk) || (w_fall && (w_mode != M_RUN || w_bkpt)))
               w_state_n = IDLE;
         end
         STEP: if (w_fall) w_state_n = IDLE;
         BURST: begin
            if ((w_mode == M_PAUSE && !r_clk) ||
                (w_fall && (r_remain == N_ONE || w_mode == M_PAUSE || w_bkpt)))
               w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_comb begin
      busy  = (r_state != IDLE);
      state = r_state;
   end

   // div is latched only at a counter restart so a phase never changes length mid-way.
   always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_div    <= '0;
         r_clk    <= 1'b0;
         r_tick   <= 1'b0;
         r_ncyc   <= '0;
         r_remain <= '0;
      end else begin
         if (!w_active || !w_stay) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
            r_div <= div;
         end else if (w_wrap) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
            r_div <= div;
         end else begin
            r_cnt <= r_cnt + C_ONE;
         end
         r_tick <= w_rise && w_stay;
         if (w_rise && w_stay) r_ncyc <= r_ncyc + N_ONE;
         if (!w_active && w_state_n == BURST)  r_remain <= burst_len;
         else if (r_state == BURST && w_fall)  r_remain <= r_remain - N_ONE;
      end
   end

   assign clock   = r_clk;
   assign tick    = r_tick;
   assign ncycles = r_ncyc;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed plus randomized bench for cpu_clock_ctrl; expected tick/busy/ncycles values come from
// period arithmetic (period = 2*(div+1), burst = n periods) rather than from the RTL structure.
module tb_cpu_clock_ctrl;
   import cpu_clock_pkg::*;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] div = 4'd0;
   logic [1:0] mode = M_PAUSE;
   logic       step = 1'b0;
   logic [7:0] burst_len = 8'd0;
   logic       clock, tick, busy;
   logic [7:0] ncycles;
   logic [1:0] state;

   int n_chk = 0, n_pass = 0;
   int n_tick = 0, n_busy = 0, n_tog = 0, hi_run = 0, last_hi = 0;
   logic prev_clk = 1'b0;
   int nc_model = 0;

`ifdef BREAKPOINT_EN
   logic [7:0] pc, bkpt = 8'd0;
   logic       bkpt_valid = 1'b0, bkpt_hit;
   assign pc = 8'(n_tick);
`endif

   cpu_clock_ctrl #(.DIV_BITS(4), .NBITS(8), .SYNC_STAGES(2)) dut (
      .clk_2(clk_2), .reset(reset), .div(div), .mode(mode), .step(step), .burst_len(burst_len),
`ifdef BREAKPOINT_EN
      .pc(pc), .bkpt(bkpt), .bkpt_valid(bkpt_valid), .bkpt_hit(bkpt_hit),
`endif
      .clock(clock), .tick(tick), .busy(busy), .ncycles(ncycles), .state(state)
   );

   always #5 clk_2 = ~clk_2;

   always @(posedge clk_2) begin
      #1;
      if (tick === 1'b1) n_tick++;
      if (busy === 1'b1) n_busy++;
      if (clock !== prev_clk) n_tog++;
      if (clock === 1'b1) hi_run++;
      else begin
         if (hi_run != 0) last_hi = hi_run;
         hi_run = 0;
      end
      prev_clk = clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_2);
   endtask

   task automatic clr();
      n_tick = 0; n_busy = 0; n_tog = 0; last_hi = 0;
   endtask

   task automatic press();
      step = 1'b1; cyc(1); step = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int k = 0;
      while (busy !== 1'b0 && k < max) begin cyc(1); k++; end
      chk(tag, busy, 0);
   endtask

   task automatic wait_tick(input string tag, input int max);
      int k = 0;
      while (tick !== 1'b1 && k < max) begin cyc(1); k++; end
      chk(tag, tick, 1);
   endtask

   initial begin
      int d, bl, exp_n, is_burst, k;
      cyc(2);
      chk("rst_clock", clock, 0);
      chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ncycles", ncycles, 0);
      chk("rst_state", state, IDLE);
      reset = 1'b1;
      cyc(3);

      // free run, div=0: entry latency then a 2-cycle period
      div = 4'd0; mode = M_RUN;
      cyc(2); chk("run_lat_pre", busy, 0);
      cyc(1); chk("run_lat", busy, 1);
      clr(); cyc(40);
      chk("run_ticks", n_tick, 20);
      chk("run_toggles", n_tog, 40);
      chk("run_ncycles", ncycles, 20);
      mode = M_PAUSE;
      wait_idle("run_stop", 20);
      chk("run_stop_clk", clock, 0);
      nc_model = 21;
      chk("run_stop_nc", ncycles, 8'(nc_model));

      // pause requested right after a rising edge: high phase must still last div+1
      cyc(4); clr();
      div = 4'd3; mode = M_RUN;
      wait_tick("hi_tick", 50);
      mode = M_PAUSE;
      wait_idle("hi_stop", 50);
      cyc(3);
      nc_model = 22;
      chk("hi_len", last_hi, 4);
      chk("hi_clk", clock, 0);
      chk("hi_nc", ncycles, 8'(nc_model));

      // single step with a second press while busy
      div = 4'd2; mode = M_STEP; cyc(4); clr();
      press(); cyc(3); press();
      wait_idle("step_idle", 50);
      chk("step_clk", clock, 0);
      cyc(8);
      nc_model = 23;
      chk("step_ticks", n_tick, 1);
      chk("step_busy", n_busy, 6);
      chk("step_hi", last_hi, 3);
      chk("step_nc", ncycles, 8'(nc_model));

      // burst of 5, then a zero-length burst
      div = 4'd1; burst_len = 8'd5; mode = M_BURST; cyc(4); clr();
      press(); cyc(3);
      wait_idle("burst_idle", 100);
      cyc(4);
      nc_model = 28;
      chk("burst_ticks", n_tick, 5);
      chk("burst_busy", n_busy, 20);
      chk("burst_nc", ncycles, 8'(nc_model));
      chk("burst_state", state, IDLE);
      burst_len = 8'd0; clr(); press(); cyc(10);
      chk("burst0_ticks", n_tick, 0);
      chk("burst0_busy", n_busy, 0);

      // randomized step/burst sessions
      for (int it = 0; it < 8; it++) begin
         d = $urandom_range(0, 5);
         bl = $urandom_range(0, 6);
         is_burst = $urandom_range(0, 1);
         div = 4'(d); burst_len = 8'(bl);
         mode = (is_burst != 0) ? M_BURST : M_STEP;
         cyc(4); clr();
         press(); cyc(3);
         wait_idle("rnd_idle", 300);
         cyc(3);
         exp_n = (is_burst != 0) ? bl : 1;
         nc_model = (nc_model + exp_n) % 256;
         chk("rnd_ticks", n_tick, exp_n);
         chk("rnd_busy", n_busy, exp_n * 2 * (d + 1));
         chk("rnd_nc", ncycles, 8'(nc_model));
      end

      // asynchronous reset while clock is high
      div = 4'd3; mode = M_RUN;
      wait_tick("ar_tick", 50);
      #2 reset = 1'b0;
      #1;
      chk("ar_clock", clock, 0);
      chk("ar_tick0", tick, 0);
      chk("ar_busy", busy, 0);
      chk("ar_nc", ncycles, 0);
      chk("ar_state", state, IDLE);
      mode = M_PAUSE;
      cyc(1); reset = 1'b1; cyc(4);
      chk("ar_post_state", state, IDLE);

      // ncycles wrap after 256 ticks
      div = 4'd0; clr(); mode = M_RUN;
      k = 0;
      while (n_tick < 255 && k < 2000) begin cyc(1); k++; end
      chk("wrap_255", ncycles, 255);
      k = 0;
      while (n_tick < 256 && k < 20) begin cyc(1); k++; end
      chk("wrap_0", ncycles, 0);
      mode = M_PAUSE;
      wait_idle("wrap_stop", 20);

`ifdef BREAKPOINT_EN
      cyc(4);
      div = 4'd1; bkpt = 8'd5; bkpt_valid = 1'b1; clr();
      mode = M_RUN;
      cyc(5);
      wait_idle("bk_idle", 200);
      cyc(10);
      chk("bk_ticks", n_tick, 5);
      chk("bk_hit", bkpt_hit, 1);
      chk("bk_busy", busy, 0);
      bkpt_valid = 1'b0; mode = M_PAUSE; cyc(5);
      chk("bk_sticky", bkpt_hit, 1);
      mode = M_RUN; cyc(5);
      chk("bk_clear", bkpt_hit, 0);
      chk("bk_rerun", busy, 1);
      mode = M_PAUSE;
      wait_idle("bk_stop", 50);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Parametrised successor to the switch-driven slow-clock toggler that sits in front of the CPU. It derives the CPU's slow `clock` from `clk_2` using a programmable divider. It adds four run modes: free-run, pause, single-step and burst of N cycles. It also provides synchronised step input, glitch-free stop (the clock always halts low) and a cycle counter for the LCD debug view.

Parameters:
DIV_BITS, 4, width of divider setting; half-period = div+1 clk_2 cycles
NBITS, 8, width of burst_len and ncycles
SYNC_STAGES, 2, flops in the mode/step input synchronisers (≥2)

Ports:
clk_2  input  1  fast board clock; only clock in block
reset  input  1  asynchronous, active-low reset
div  input  DIV_BITS  half-period select; sampled only when the counter restarts
mode  input  2  00 RUN, 01 PAUSE, 10 STEP, 11 BURST; asynchronous, synchronised internally
step  input  1  step/burst trigger button; asynchronous, synchronised and edge-detected
burst_len  input  NBITS  periods per BURST; latched on burst start
clock  output  1  slow CPU clock, registered
tick  output  1  one-clk_2 pulse in the cycle clock goes 0→1
busy  output  1  high in RUN/STEP/BURST states
ncycles  output  NBITS  count of slow rising edges; wraps
state  output  2  current FSM state, for LCD

Behaviour:
- Reset (reset=0, asynchronous): clock=0, tick=0, busy=0, ncycles=0, state=IDLE. Divider counter, burst remaining count and sync flops all clear.
- Synchronisation:
  - mode and step each pass through SYNC_STAGES flops.
  - step_rise = synced step & ~previous synced step, so trigger latency is SYNC_STAGES+1 cycles.
- Divider:
  - In active states, cnt increments each clk_2 cycle. When cnt==div, clock toggles and cnt returns to 0.
  - div=0 gives a 2-cycle period, the same as the legacy toggler.
  - In IDLE, cnt is held at 0 and clock is held at 0.
  - On entering an active state, the first rising edge occurs div+1 cycles later.
- tick is registered; it is high exactly in the cycle clock becomes 1. ncycles increments on every tick, and 2^NBITS-1 wraps to 0.
- FSM states are IDLE, RUN, STEP and BURST. "Falling edge" means clock toggling 1→0.
  - IDLE→RUN: mode==RUN.
  - IDLE→STEP: mode==STEP and step_rise.
  - IDLE→BURST: mode==BURST, step_rise and burst_len≠0; remaining<=burst_len. If burst_len==0, stay IDLE and emit no tick.
  - RUN→IDLE: mode≠RUN, taken at the next falling edge. If clock is high, the high half completes first; if clock is low, stop immediately and reset cnt.
  - STEP→IDLE: at the first falling edge, i.e. exactly one period of 2·(div+1) cycles.
  - BURST: remaining decrements at each falling edge. At the falling edge where remaining==1, go to IDLE.
  - BURST with mode changed to PAUSE: abort at the next falling edge, or immediately if clock is low. Other mode changes are ignored until the burst completes.
- step_rise while not IDLE is ignored and not queued.
- Clock never produces a runt pulse: the high phase always lasts div+1 cycles. A div change takes effect at the next counter restart.
- Reset asserted mid-period: clock drops to 0 asynchronously; this is accepted.

Optional Feature:
BREAKPOINT_EN
- With the macro defined:
  - Adds ports pc (in, NBITS), bkpt (in, NBITS), bkpt_valid (in, 1) and bkpt_hit (out, 1, reset 0).
  - In RUN or BURST, at each falling edge, if bkpt_valid && pc==bkpt: go to IDLE and set bkpt_hit.
  - bkpt_hit is sticky and clears on the next entry to any active state.
  - STEP ignores the breakpoint.
- Without the macro: none of these ports exist, and behaviour is as above.

Decomposition:
- Package cpu_clock_pkg holds:
  - typedef enum logic[1:0] state_t {IDLE, RUN, STEP, BURST};
  - typedef enum logic[1:0] mode_t {M_RUN, M_PAUSE, M_STEP, M_BURST}.
- Sub-module sync_edge, parametrised by SYNC_STAGES: a synchroniser plus rising-edge detector, instantiated for step (and its level output reused for mode bits).

Test Plan:
- Reset: run with div=3, pull reset low while clock=1 → all outputs 0 in the same cycle; after release, state=IDLE.
- Free run: mode=RUN, div=0 for 40 clk_2 cycles → clock toggles every cycle, tick every 2nd cycle, ncycles=20.
- Single step: mode=STEP, div=2, one step press → exactly one 6-cycle period, ncycles 0→1, busy falls at the falling edge. A second press during busy gives no extra tick.
- Burst: mode=BURST, burst_len=5, div=1 → exactly 5 ticks, 20 cycles busy, then IDLE. Repeat with burst_len=0 → no ticks, busy stays 0.
- Stop while high: RUN with div=3, switch to PAUSE right after tick → clock stays high 4 cycles total, then held 0. Check no runt high pulse.
- Wrap/breakpoint: NBITS=8, 256 ticks → ncycles=0. With BREAKPOINT_EN, bkpt=5 and pc incrementing per tick → halt at the falling edge with pc==5; bkpt_hit=1 until the next RUN.
